ccr_branch_unit: RTL

- Consumer side of the ALU flag interface: holds the condition-code register (CCR: bit2 N, bit1 C, bit0 Z) written by the execute-stage ALU.
- Executes SETC/CLRC and resolves conditional/unconditional jumps against the CCR.
- Saves and restores the CCR across one level of interrupt (INT/RTI).
- Sits in the execute stage beside the ALU and drives PC-select and a pipeline flush.

---
 rtl/ccr_branch_unit.sv | 65 ++++++
 1 files changed

// File: rtl/ccr_branch_unit.sv
// ccr_branch_unit: condition-code register, SETC/CLRC, branch resolution and single-level interrupt save/restore
// Ports: clk, rst (async, active-high); stall freezes state and suppresses branches;
//   flag_in/flag_mask masked ALU flag write {N,C,Z}; set_c/clr_c force carry;
//   br_op 0 none, 1 JZ, 2 JN, 3 JC, 4 JMP; int_save/rti save and restore the CCR;
//   ccr_out registered CCR; take_branch same-cycle decision; flush and rti_err registered pulses.
module ccr_branch_unit #(
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [FLAG_W-1:0] flag_in,
  input  logic [FLAG_W-1:0] flag_mask,
  input  logic              set_c,
  input  logic              clr_c,
  input  logic [2:0]        br_op,
  input  logic              int_save,
  input  logic              rti,
  output logic [FLAG_W-1:0] ccr_out,
  output logic              take_branch,
  output logic              flush,
  output logic              rti_err
);
  logic [FLAG_W-1:0] ccr, shadow, masked, next_ccr, consume;
  logic              shadow_valid;
  always_comb begin
    take_branch = !stall && (br_op == 3'd1 ? ccr[0] :
                             br_op == 3'd2 ? ccr[2] :
                             br_op == 3'd3 ? ccr[1] :
                             br_op == 3'd4);
    masked      = (ccr & ~flag_mask) | (flag_in & flag_mask);
    masked[1]   = set_c ? 1'b1 : clr_c ? 1'b0 : masked[1];
    // a taken conditional branch consumes the flag it tested
    consume     = !take_branch ? 3'b000 :
                  br_op == 3'd1 ? 3'b001 :
                  br_op == 3'd2 ? 3'b100 :
                  br_op == 3'd3 ? 3'b010 : 3'b000;
    next_ccr    = masked & ~consume;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr          <= '0;
      shadow       <= '0;
      shadow_valid <= 1'b0;
      flush        <= 1'b0;
      rti_err      <= 1'b0;
    end else begin
      flush   <= take_branch;
      rti_err <= !stall && rti && !shadow_valid;
      if (!stall) begin
        if (rti && shadow_valid) begin
          ccr          <= shadow;
          shadow_valid <= 1'b0;
        end else begin
          ccr <= next_ccr;
          if (int_save && !rti) begin
            shadow       <= next_ccr;
            shadow_valid <= 1'b1;
          end
        end
      end
    end
  end
  assign ccr_out = ccr;
endmodule
